proc_sequencer: RTL and testbench
=================================

# proc_sequencer

Program sequencer for the 9-bit multi-cycle processor. It fetches instruction words from a synchronous program ROM, presents each one on the processor's `DIN` with a one-cycle `Run` pulse, and supplies the immediate word for MVI in the following cycle. It then waits for `Done` before fetching the next word. The block sits between the program ROM and the processor top level, and supports free-run, single-step, halt and a watchdog error stop.

## Interface
- `ADDR_W`, 5: program address width; ROM depth 2^ADDR_W words.
- `TIMEOUT`, 15: maximum WAIT cycles without `Done` before error (≥2).
- `clk_50`  in  1  system clock; all state changes on rising edge.
- `Resetn`  in  1  asynchronous, active-low reset.
- `Start`  in  1  begin execution from address 0; sampled in IDLE, HALT, ERROR.
- `Step_mode`  in  1  1 = pause after every instruction.
- `Step`  in  1  single-cycle pulse; releases PAUSE.
- `mem_addr`  out  ADDR_W  ROM address; ROM data valid the cycle after.
- `mem_data`  in  9  ROM read data.
- `DIN`  out  9  word driven to the processor.
- `Run`  out  1  one-cycle issue pulse to the processor.
- `Done`  in  1  processor completion; sampled only in WAIT.
- `PC`  out  ADDR_W  address of the next word to fetch.
- `Busy`  out  1  high in every state except IDLE, HALT and ERROR.
- `Halted`  out  1  halt word executed.
- `Err`  out  1  watchdog expired.

## Operation
- States: IDLE, FETCH, DECODE, IMM_FETCH, IMM_LATCH, ISSUE, WAIT, PAUSE, HALT, ERROR.
- Outputs are Moore-decoded from state and registers: `Run` = (state==ISSUE), `Halted` = (state==HALT), `Err` = (state==ERROR).
- Transitions:
  - IDLE: `Start` → FETCH with PC=0.
  - FETCH: `mem_addr`=PC → DECODE.
  - DECODE: latch `mem_data` into instr_q and PC←PC+1.
    - If word==9'h1FF (HALT_WORD) → HALT.
    - Else if opcode [8:6]==3'b001 (MVI) → IMM_FETCH.
    - Else → ISSUE.
  - IMM_FETCH: `mem_addr`=PC → IMM_LATCH.
  - IMM_LATCH: latch imm_q, PC←PC+1 → ISSUE.
  - ISSUE: `DIN`=instr_q, `Run`=1 → WAIT. Watchdog is cleared.
  - WAIT: `DIN`=imm_q for MVI, otherwise instr_q.
    - `Done` → PAUSE if `Step_mode`, else FETCH.
    - Otherwise the watchdog increments; on the TIMEOUT-th consecutive WAIT cycle without `Done` → ERROR.
  - PAUSE: `Step` or !`Step_mode` → FETCH.
  - HALT, ERROR: sticky. `Start` → FETCH with PC=0.
- Reserved opcodes 100–110 are issued like MV. The processor returns `Done` for them.
- PC is an ADDR_W-bit counter. It wraps from 2^ADDR_W−1 to 0 with no flag. The MVI immediate may come from the wrapped address.
- `Start` while `Busy`: ignored. `Step` outside PAUSE: ignored.
- `Done` in any state other than WAIT: ignored.

## Timing
- Reset values: state=IDLE; PC, `mem_addr`, `DIN`, instr_q, imm_q, watchdog = 0; `Run`, `Busy`, `Halted`, `Err` = 0.
- Reset is asynchronous and aborts any state, including WAIT mid-instruction. `Run` drops immediately.
- Let edge k be the edge that samples `Start`.
  - Non-MVI: `Run` is high in the cycle after edge k+2 (3 cycles of latency).
  - MVI: `Run` is high after edge k+4.
- `DIN` holds the immediate from the cycle after the `Run` cycle until the cycle in which `Done` is sampled.
- `Done` sampled at edge m (free-run): the next `Run` follows edge m+2 (non-MVI).
- `Done` is accepted in the first WAIT cycle, i.e. the cycle right after `Run`.

## Structure
- Package `proc_seq_pkg`:
  - state enum `seq_state_t`
  - `HALT_WORD` = 9'h1FF
  - `OPC_MVI` = 3'b001
  - function `is_mvi(logic [8:0])`
- Sub-module `proc_seq_watchdog`: loadable down-counter with clear, enable and expire outputs, parameterised by TIMEOUT.
- The FSM, PC and operand registers live in `proc_sequencer`.

## Test plan
- **MV then halt.** ROM[0]=9'o012, ROM[1]=9'h1FF; processor model returns `Done` one cycle after `Run`. Required: exactly one `Run`, with `DIN`=9'o012; then `Halted`=1, PC=2, `Busy`=0.
- **MVI immediate.** ROM[0]=9'o130, ROM[1]=9'h05A, ROM[2]=9'h1FF; model returns `Done` 3 cycles after `Run`. Required: `DIN`=9'o130 during `Run`, then 9'h05A for 3 cycles; then `Halted`=1, PC=3.
- **Watchdog.** `Done` tied low, TIMEOUT=15. Required: `Err`=1 starting 16 cycles after the `Run` cycle; `Start` restarts with PC=0 and `Err`=0.
- **Step mode.** `Step_mode`=1 with a 3-instruction program. Required: the sequencer stays in PAUSE after each `Done`, and each `Step` pulse produces exactly one further `Run`.
- **Reset mid-operation.** `Resetn` low during WAIT of an MVI. Required: all outputs return to reset values asynchronously; the next `Start` begins again at PC=0.
- **Wrap.** ADDR_W=2, ROM holds 4 MV words with no halt. Required: `mem_addr` sequence is 0,1,2,3,0,1… and PC wraps to 0 with no error.

Source files
------------

// File: rtl/proc_seq_pkg.sv
// Shared types and constants for the 9-bit processor program sequencer.
package proc_seq_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_IMM_FETCH,
        S_IMM_LATCH,
        S_ISSUE,
        S_WAIT,
        S_PAUSE,
        S_HALT,
        S_ERROR
    } seq_state_t;

    localparam logic [8:0] HALT_WORD = 9'h1FF;
    localparam logic [2:0] OPC_MVI   = 3'b001;

    function automatic logic is_mvi(input logic [8:0] word);
        return word[8:6] == OPC_MVI;
    endfunction

endpackage

// File: rtl/proc_seq_watchdog.sv
// Loadable down-counter that flags when the processor has not answered
// within TIMEOUT consecutive enabled cycles.
module proc_seq_watchdog #(
    parameter int TIMEOUT = 15
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             load_i,
    input  logic                             en_i,
    output logic                             expire_o,
    output logic [$clog2(TIMEOUT+1)-1:0]     count_o
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Loaded to TIMEOUT-1 so the TIMEOUT-th enabled cycle sees zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD_VAL;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    assign expire_o = en_i && (cnt_q == '0);
    assign count_o  = cnt_q;

endmodule

// File: rtl/proc_sequencer.sv
// Program sequencer: fetches words from a synchronous ROM, issues them to the
// processor with a Run pulse, supplies MVI immediates and waits for Done.
module proc_sequencer
    import proc_seq_pkg::*;
#(
    parameter int ADDR_W  = 5,
    parameter int TIMEOUT = 15
) (
    input  logic              clk_50,
    input  logic              Resetn,
    input  logic              Start,
    input  logic              Step_mode,
    input  logic              Step,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [8:0]        mem_data,
    output logic [8:0]        DIN,
    output logic              Run,
    input  logic              Done,
    output logic [ADDR_W-1:0] PC,
    output logic              Busy,
    output logic              Halted,
    output logic              Err,
    output seq_state_t        state_o
);

    seq_state_t        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [8:0]        instr_q, instr_d;
    logic [8:0]        imm_q, imm_d;
    logic              wd_load, wd_en, wd_expire;
    logic [$clog2(TIMEOUT+1)-1:0] wd_count;
    logic              restart;

    assign restart = Start && ((state_q == S_IDLE) || (state_q == S_HALT) || (state_q == S_ERROR));

    always_ff @(posedge clk_50 or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_HALT, S_ERROR: if (Start) state_d = S_FETCH;
            S_FETCH:     state_d = S_DECODE;
            S_DECODE: begin
                if (mem_data == HALT_WORD)  state_d = S_HALT;
                else if (is_mvi(mem_data))  state_d = S_IMM_FETCH;
                else                        state_d = S_ISSUE;
            end
            S_IMM_FETCH: state_d = S_IMM_LATCH;
            S_IMM_LATCH: state_d = S_ISSUE;
            S_ISSUE:     state_d = S_WAIT;
            S_WAIT: begin
                if (Done)           state_d = Step_mode ? S_PAUSE : S_FETCH;
                else if (wd_expire) state_d = S_ERROR;
            end
            S_PAUSE:     if (Step || !Step_mode) state_d = S_FETCH;
            default:     state_d = S_IDLE;
        endcase
    end

    always_comb begin
        Run      = (state_q == S_ISSUE);
        Halted   = (state_q == S_HALT);
        Err      = (state_q == S_ERROR);
        Busy     = !((state_q == S_IDLE) || (state_q == S_HALT) || (state_q == S_ERROR));
        // The immediate follows the opcode word once the Run cycle is over.
        DIN      = ((state_q == S_WAIT) && is_mvi(instr_q)) ? imm_q : instr_q;
        mem_addr = pc_q;
        PC       = pc_q;
        state_o  = state_q;
        wd_load  = (state_q == S_ISSUE);
        wd_en    = (state_q == S_WAIT) && !Done;
    end

    always_ff @(posedge clk_50 or negedge Resetn) begin
        if (!Resetn) begin
            pc_q    <= '0;
            instr_q <= '0;
            imm_q   <= '0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            imm_q   <= imm_d;
        end
    end

    // PC wraps naturally at 2^ADDR_W; an MVI at the top address takes word 0.
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        imm_d   = imm_q;
        if (restart) begin
            pc_d = '0;
        end else if (state_q == S_DECODE) begin
            instr_d = mem_data;
            pc_d    = pc_q + ADDR_W'(1);
        end else if (state_q == S_IMM_LATCH) begin
            imm_d = mem_data;
            pc_d  = pc_q + ADDR_W'(1);
        end
    end

    proc_seq_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk      (clk_50),
        .rst_n    (Resetn),
        .load_i   (wd_load),
        .en_i     (wd_en),
        .expire_o (wd_expire),
        .count_o  (wd_count)
    );

endmodule

// File: tb/tb_proc_sequencer.sv
// Self-checking bench for proc_sequencer: ROM and processor models plus an
// instruction-level reference walk of the program.
module tb_proc_sequencer;
  import proc_seq_pkg::*;

  localparam int ADDR_W  = 5;
  localparam int TIMEOUT = 15;
  localparam int DEPTH   = 1 << ADDR_W;

  logic              clk_50 = 1'b0;
  logic              Resetn, Start, Step_mode, Step;
  logic              Done = 1'b0;
  logic [8:0]        mem_data = 9'h000;
  logic [8:0]        DIN;
  logic [ADDR_W-1:0] mem_addr, PC;
  logic              Run, Busy, Halted, Err;
  seq_state_t        state_o;

  always #5 clk_50 = ~clk_50;

  proc_sequencer #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_50(clk_50), .Resetn(Resetn), .Start(Start), .Step_mode(Step_mode),
    .Step(Step), .mem_addr(mem_addr), .mem_data(mem_data), .DIN(DIN),
    .Run(Run), .Done(Done), .PC(PC), .Busy(Busy), .Halted(Halted),
    .Err(Err), .state_o(state_o)
  );

  // synchronous program ROM
  logic [8:0] rom [DEPTH];
  always @(posedge clk_50) mem_data <= rom[mem_addr];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk_50) cyc <= cyc + 1;

  // processor model and observation queues
  bit done_en = 1'b1;
  bit rand_delay = 1'b0;
  int fixed_delay = 1;
  int cnt = 0, wlen = 0, last_ref = 0;
  bit in_wait = 1'b0;
  logic [8:0]        run_din_q[$];
  logic [ADDR_W-1:0] run_pc_q[$];
  int                run_cyc_q[$];
  int                lat_q[$];
  logic [8:0]        wait_q[$];
  int                wait_len_q[$];
  int                delay_q[$];

  always @(negedge clk_50) begin
    if (!Resetn) begin
      cnt = 0; Done = 1'b0; in_wait = 1'b0;
      run_din_q.delete(); run_pc_q.delete(); run_cyc_q.delete(); lat_q.delete();
      wait_q.delete(); wait_len_q.delete(); delay_q.delete();
    end else begin
      if (Start && !Busy) last_ref = cyc;
      if (Err) begin cnt = 0; in_wait = 1'b0; end
      if (Run) begin
        cnt = rand_delay ? int'($urandom_range(1, 4)) : fixed_delay;
        delay_q.push_back(cnt);
        Done = 1'b0;
      end else if (cnt > 0 && done_en) begin
        cnt--;
        Done = (cnt == 0);
      end else begin
        Done = 1'b0;
      end
      if (Run) begin
        run_din_q.push_back(DIN); run_pc_q.push_back(PC);
        run_cyc_q.push_back(cyc); lat_q.push_back(cyc - last_ref);
        in_wait = 1'b1; wlen = 0;
      end else if (in_wait) begin
        wait_q.push_back(DIN); wlen++;
        if (Done) begin in_wait = 1'b0; wait_len_q.push_back(wlen); last_ref = cyc; end
      end
    end
  end

  // reference model: walk the program at instruction level
  logic [8:0]        exp_din_q[$];
  logic [8:0]        exp_wv_q[$];
  logic [ADDR_W-1:0] exp_pc_q[$];
  int                exp_lat_q[$];
  int                model_pc;
  bit                model_halt;

  task automatic model_program(input int max_instr);
    int pc;
    logic [8:0] w;
    pc = 0; model_halt = 1'b0;
    exp_din_q.delete(); exp_wv_q.delete(); exp_pc_q.delete(); exp_lat_q.delete();
    for (int n = 0; n < max_instr; n++) begin
      w = rom[pc]; pc = (pc + 1) % DEPTH;
      if (w == 9'h1FF) begin model_halt = 1'b1; break; end
      exp_din_q.push_back(w);
      if (w[8:6] == 3'b001) begin
        exp_wv_q.push_back(rom[pc]); exp_lat_q.push_back(5); pc = (pc + 1) % DEPTH;
      end else begin
        exp_wv_q.push_back(w); exp_lat_q.push_back(3);
      end
      exp_pc_q.push_back(ADDR_W'(pc));
    end
    model_pc = pc;
  endtask

  task automatic fill_rom(input logic [8:0] w);
    for (int i = 0; i < DEPTH; i++) rom[i] = w;
  endtask

  task automatic apply_reset();
    Resetn = 1'b0; Start = 1'b0; Step = 1'b0; Step_mode = 1'b0;
    done_en = 1'b1; rand_delay = 1'b0; fixed_delay = 1;
    repeat (2) @(posedge clk_50);
    #1 Resetn = 1'b1;
  endtask

  task automatic pulse_start();
    @(posedge clk_50); #1 Start = 1'b1;
    @(posedge clk_50); #1 Start = 1'b0;
  endtask

  task automatic pulse_step();
    @(posedge clk_50); #1 Step = 1'b1;
    @(posedge clk_50); #1 Step = 1'b0;
  endtask

  task automatic wait_stop(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_50); #1;
      if (Halted || Err) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_runs(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_50); #1;
      if (run_din_q.size() >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk_50); #1;
    checks++; if (Run !== 1'b0)    begin errors++; $display("FAIL reset_run: got %b want 0", Run); end
    checks++; if (Busy !== 1'b0)   begin errors++; $display("FAIL reset_busy: got %b want 0", Busy); end
    checks++; if (Halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b want 0", Halted); end
    checks++; if (Err !== 1'b0)    begin errors++; $display("FAIL reset_err: got %b want 0", Err); end
    checks++; if (PC !== 5'd0)     begin errors++; $display("FAIL reset_pc: got %0d want 0", PC); end
    checks++; if (mem_addr !== 5'd0) begin errors++; $display("FAIL reset_addr: got %0d want 0", mem_addr); end
    checks++; if (DIN !== 9'h000)  begin errors++; $display("FAIL reset_din: got %h want 000", DIN); end
  endtask

  task automatic test_mv_halt();
    bit ok;
    apply_reset();
    fill_rom(9'h000); rom[0] = 9'o012; rom[1] = 9'h1FF;
    fixed_delay = 1;
    pulse_start();
    wait_stop(100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL mv_stop: no halt within budget"); end
    checks++; if (run_din_q.size() != 1) begin errors++; $display("FAIL mv_runs: got %0d want 1", run_din_q.size()); end
    if (run_din_q.size() > 0) begin
      checks++; if (run_din_q[0] !== 9'o012) begin errors++; $display("FAIL mv_din: got %o want 012", run_din_q[0]); end
      checks++; if (lat_q[0] != 3) begin errors++; $display("FAIL mv_latency: got %0d want 3", lat_q[0]); end
    end
    checks++; if (Halted !== 1'b1) begin errors++; $display("FAIL mv_halted: got %b want 1", Halted); end
    checks++; if (PC !== 5'd2)     begin errors++; $display("FAIL mv_pc: got %0d want 2", PC); end
    checks++; if (Busy !== 1'b0)   begin errors++; $display("FAIL mv_busy: got %b want 0", Busy); end
  endtask

  task automatic test_mvi();
    bit ok;
    apply_reset();
    fill_rom(9'h000); rom[0] = 9'o130; rom[1] = 9'h05A; rom[2] = 9'h1FF;
    fixed_delay = 3;
    pulse_start();
    wait_stop(100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL mvi_stop: no halt within budget"); end
    checks++; if (run_din_q.size() != 1) begin errors++; $display("FAIL mvi_runs: got %0d want 1", run_din_q.size()); end
    if (run_din_q.size() > 0) begin
      checks++; if (run_din_q[0] !== 9'o130) begin errors++; $display("FAIL mvi_din: got %o want 130", run_din_q[0]); end
      checks++; if (lat_q[0] != 5) begin errors++; $display("FAIL mvi_latency: got %0d want 5", lat_q[0]); end
    end
    checks++; if (wait_q.size() != 3) begin errors++; $display("FAIL mvi_imm_len: got %0d want 3", wait_q.size()); end
    foreach (wait_q[i]) begin
      checks++; if (wait_q[i] !== 9'h05A) begin errors++; $display("FAIL mvi_imm[%0d]: got %h want 05a", i, wait_q[i]); end
    end
    checks++; if (Halted !== 1'b1) begin errors++; $display("FAIL mvi_halted: got %b want 1", Halted); end
    checks++; if (PC !== 5'd3)     begin errors++; $display("FAIL mvi_pc: got %0d want 3", PC); end
  endtask

  task automatic test_random_programs();
    bit ok;
    int len, k, n;
    for (int it = 0; it < 6; it++) begin
      apply_reset();
      fill_rom(9'h1FF);
      len = $urandom_range(3, 12);
      for (int i = 0; i < len; i++) rom[i] = 9'($urandom_range(0, 510));
      rand_delay = 1'b1;
      model_program(64);
      pulse_start();
      wait_stop(2000, ok);
      n = exp_din_q.size();
      checks++; if (!ok || !Halted) begin errors++; $display("FAIL rand%0d_halt: halted=%b want 1", it, Halted); end
      checks++; if (run_din_q.size() != n) begin errors++; $display("FAIL rand%0d_runs: got %0d want %0d", it, run_din_q.size(), n); end
      checks++; if (PC !== ADDR_W'(model_pc)) begin errors++; $display("FAIL rand%0d_pc: got %0d want %0d", it, PC, model_pc); end
      k = 0;
      for (int i = 0; i < n && i < run_din_q.size(); i++) begin
        checks++; if (run_din_q[i] !== exp_din_q[i]) begin errors++; $display("FAIL rand%0d_din[%0d]: got %h want %h", it, i, run_din_q[i], exp_din_q[i]); end
        checks++; if (run_pc_q[i] !== exp_pc_q[i]) begin errors++; $display("FAIL rand%0d_runpc[%0d]: got %0d want %0d", it, i, run_pc_q[i], exp_pc_q[i]); end
        checks++; if (lat_q[i] != exp_lat_q[i]) begin errors++; $display("FAIL rand%0d_lat[%0d]: got %0d want %0d", it, i, lat_q[i], exp_lat_q[i]); end
        if (i < wait_len_q.size()) begin
          checks++; if (wait_len_q[i] != delay_q[i]) begin errors++; $display("FAIL rand%0d_waitlen[%0d]: got %0d want %0d", it, i, wait_len_q[i], delay_q[i]); end
          for (int j = 0; j < wait_len_q[i] && k < wait_q.size(); j++) begin
            checks++; if (wait_q[k] !== exp_wv_q[i]) begin errors++; $display("FAIL rand%0d_wait[%0d]: got %h want %h", it, i, wait_q[k], exp_wv_q[i]); end
            k++;
          end
        end
      end
    end
  endtask

  task automatic test_watchdog();
    bit ok;
    int err_cyc;
    apply_reset();
    fill_rom(9'h1FF); rom[0] = 9'o012;
    done_en = 1'b0;
    pulse_start();
    ok = 1'b0; err_cyc = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_50); #1;
      if (Err) begin ok = 1'b1; err_cyc = cyc; break; end
    end
    checks++; if (!ok) begin errors++; $display("FAIL wd_err: Err never rose"); end
    if (ok && run_cyc_q.size() > 0) begin
      checks++; if (err_cyc - run_cyc_q[0] != TIMEOUT + 1) begin errors++; $display("FAIL wd_delay: got %0d want %0d", err_cyc - run_cyc_q[0], TIMEOUT + 1); end
    end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL wd_busy: got %b want 0", Busy); end
    checks++; if (Run !== 1'b0)  begin errors++; $display("FAIL wd_run: got %b want 0", Run); end
    done_en = 1'b1;
    repeat (3) @(negedge clk_50);
    #1;
    checks++; if (Err !== 1'b1) begin errors++; $display("FAIL wd_sticky: got %b want 1", Err); end
    pulse_start();
    checks++; if (PC !== 5'd0)   begin errors++; $display("FAIL wd_restart_pc: got %0d want 0", PC); end
    checks++; if (Err !== 1'b0)  begin errors++; $display("FAIL wd_restart_err: got %b want 0", Err); end
    checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL wd_restart_busy: got %b want 1", Busy); end
    wait_stop(100, ok);
    checks++; if (!ok || !Halted) begin errors++; $display("FAIL wd_restart_halt: halted=%b want 1", Halted); end
    checks++; if (PC !== 5'd2)   begin errors++; $display("FAIL wd_restart_endpc: got %0d want 2", PC); end
  endtask

  task automatic test_step();
    bit ok;
    logic [8:0] exp_w [3];
    apply_reset();
    fill_rom(9'h1FF);
    rom[0] = 9'o012; rom[1] = 9'o130; rom[2] = 9'h05A; rom[3] = 9'o421;
    exp_w[0] = 9'o012; exp_w[1] = 9'o130; exp_w[2] = 9'o421;
    Step_mode = 1'b1; fixed_delay = 2;
    pulse_step();
    pulse_start();
    for (int k = 0; k < 3; k++) begin
      wait_runs(k + 1, 60, ok);
      checks++; if (!ok) begin errors++; $display("FAIL step%0d_run: no Run within budget", k); end
      for (int i = 0; i < 20 && wait_len_q.size() < k + 1; i++) begin @(negedge clk_50); #1; end
      repeat (8) @(negedge clk_50);
      #1;
      checks++; if (run_din_q.size() != k + 1) begin errors++; $display("FAIL step%0d_count: got %0d want %0d", k, run_din_q.size(), k + 1); end
      checks++; if (state_o !== S_PAUSE) begin errors++; $display("FAIL step%0d_pause: got %s want S_PAUSE", k, state_o.name()); end
      checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL step%0d_busy: got %b want 1", k, Busy); end
      if (run_din_q.size() > k) begin
        checks++; if (run_din_q[k] !== exp_w[k]) begin errors++; $display("FAIL step%0d_din: got %o want %o", k, run_din_q[k], exp_w[k]); end
      end
      pulse_step();
    end
    wait_stop(50, ok);
    checks++; if (!ok || !Halted) begin errors++; $display("FAIL step_halt: halted=%b want 1", Halted); end
    checks++; if (PC !== 5'd5) begin errors++; $display("FAIL step_pc: got %0d want 5", PC); end
    checks++; if (run_din_q.size() != 3) begin errors++; $display("FAIL step_total: got %0d want 3", run_din_q.size()); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    apply_reset();
    fill_rom(9'h1FF); rom[0] = 9'o130; rom[1] = 9'h0A5;
    fixed_delay = 12;
    pulse_start();
    wait_runs(1, 50, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rmid_run: no Run within budget"); end
    repeat (3) @(negedge clk_50);
    #2 Resetn = 1'b0;
    #1;
    checks++; if (DIN !== 9'h000) begin errors++; $display("FAIL rmid_din: got %h want 000", DIN); end
    checks++; if (PC !== 5'd0)    begin errors++; $display("FAIL rmid_pc: got %0d want 0", PC); end
    checks++; if (mem_addr !== 5'd0) begin errors++; $display("FAIL rmid_addr: got %0d want 0", mem_addr); end
    checks++; if (Busy !== 1'b0 || Run !== 1'b0 || Halted !== 1'b0 || Err !== 1'b0) begin
      errors++; $display("FAIL rmid_flags: busy=%b run=%b halted=%b err=%b want 0000", Busy, Run, Halted, Err);
    end
    repeat (2) @(posedge clk_50);
    #1 Resetn = 1'b1;
    fixed_delay = 1;
    pulse_start();
    wait_stop(100, ok);
    checks++; if (run_din_q.size() != 1) begin errors++; $display("FAIL rmid_runs: got %0d want 1", run_din_q.size()); end
    if (run_din_q.size() > 0) begin
      checks++; if (run_din_q[0] !== 9'o130) begin errors++; $display("FAIL rmid_din2: got %o want 130", run_din_q[0]); end
      checks++; if (run_pc_q[0] !== 5'd2) begin errors++; $display("FAIL rmid_runpc: got %0d want 2", run_pc_q[0]); end
      checks++; if (lat_q[0] != 5) begin errors++; $display("FAIL rmid_latency: got %0d want 5", lat_q[0]); end
    end
    checks++; if (!ok || PC !== 5'd3) begin errors++; $display("FAIL rmid_endpc: got %0d want 3", PC); end
  endtask

  task automatic test_wrap();
    bit ok;
    int k;
    apply_reset();
    for (int i = 0; i < DEPTH; i++) rom[i] = {3'b010, 6'(i)};
    rom[DEPTH-1] = {3'b001, 6'(DEPTH - 1)};
    model_program(40);
    pulse_start();
    wait_runs(40, 2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL wrap_runs: got %0d want 40", run_din_q.size()); end
    checks++; if (Err !== 1'b0 || Halted !== 1'b0) begin errors++; $display("FAIL wrap_flags: err=%b halted=%b want 00", Err, Halted); end
    k = 0;
    for (int i = 0; i < 40 && i < run_din_q.size(); i++) begin
      checks++; if (run_din_q[i] !== exp_din_q[i]) begin errors++; $display("FAIL wrap_din[%0d]: got %h want %h", i, run_din_q[i], exp_din_q[i]); end
      checks++; if (run_pc_q[i] !== exp_pc_q[i]) begin errors++; $display("FAIL wrap_pc[%0d]: got %0d want %0d", i, run_pc_q[i], exp_pc_q[i]); end
      checks++; if (lat_q[i] != exp_lat_q[i]) begin errors++; $display("FAIL wrap_lat[%0d]: got %0d want %0d", i, lat_q[i], exp_lat_q[i]); end
      if (i < wait_len_q.size() && k < wait_q.size()) begin
        checks++; if (wait_q[k] !== exp_wv_q[i]) begin errors++; $display("FAIL wrap_wait[%0d]: got %h want %h", i, wait_q[k], exp_wv_q[i]); end
        k = k + wait_len_q[i];
      end
    end
    apply_reset();
  endtask

  initial begin
    Resetn = 1'b0; Start = 1'b0; Step = 1'b0; Step_mode = 1'b0;
    test_reset();
    test_mv_halt();
    test_mvi();
    test_random_programs();
    test_watchdog();
    test_step();
    test_reset_mid();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
